// File: rtl/debounce_bank.sv
// debounce_bank: multi-channel key/switch conditioner.
// Each channel has a synchroniser, a stability counter that drives a
// debounced level, registered edge strobes and an optional auto-repeat
// strobe. Channels are independent lanes instantiated in a generate loop.

module debounce_lane #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 500000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_RATE   = 5000000,
  parameter bit ACTIVE_LOW    = 1'b1,
  parameter bit INIT_LEVEL    = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_in,
  input  logic i_repeat_en,
  output logic o_level,
  output logic o_pos,
  output logic o_neg,
  output logic o_repeat
);
  localparam int CW   = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RCW  = (RMAX > 1) ? $clog2(RMAX) : 1;

  localparam logic [CW-1:0]  ST_MAX   = CW'(STABLE_CYCLES - 1);
  localparam logic [RCW-1:0] DLY_MAX  = RCW'(REPEAT_DELAY - 1);
  localparam logic [RCW-1:0] RATE_MAX = RCW'(REPEAT_RATE - 1);

  localparam logic [0:0] PH_DELAY = 1'b0;
  localparam logic [0:0] PH_RATE  = 1'b1;

  // Level that counts as "pressed".
  localparam logic PRESS_LVL = ~ACTIVE_LOW;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   level_q, level_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   pos_q, pos_d, neg_q, neg_d;
  logic [RCW-1:0]         rcnt_q, rcnt_d;
  logic [0:0]             ph_q, ph_d;
  logic                   rep_q, rep_d;
  logic                   flip;

  assign s = sync_q[SYNC_STAGES-1];

  // Stability counter: level follows s only after it has differed long enough.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    pos_d   = 1'b0;
    neg_d   = 1'b0;
    if (s == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == ST_MAX) begin
      level_d = s;
      cnt_d   = '0;
      pos_d   = s;
      neg_d   = ~s;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign flip = (level_d != level_q);

  // Auto-repeat: any level change this edge (press or release) restarts the
  // DELAY phase and suppresses o_repeat, so release beats a coincident repeat.
  always_comb begin
    rcnt_d = rcnt_q;
    ph_d   = ph_q;
    rep_d  = 1'b0;
    if (flip || (level_q != PRESS_LVL) || !i_repeat_en) begin
      rcnt_d = '0;
      ph_d   = PH_DELAY;
    end else if ((ph_q == PH_DELAY) && (rcnt_q == DLY_MAX)) begin
      rep_d  = 1'b1;
      rcnt_d = '0;
      ph_d   = PH_RATE;
    end else if ((ph_q == PH_RATE) && (rcnt_q == RATE_MAX)) begin
      rep_d  = 1'b1;
      rcnt_d = '0;
    end else begin
      rcnt_d = rcnt_q + RCW'(1);
    end
  end

  // State registers, including the synchroniser chain.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q  <= {SYNC_STAGES{INIT_LEVEL}};
      level_q <= INIT_LEVEL;
      cnt_q   <= '0;
      pos_q   <= 1'b0;
      neg_q   <= 1'b0;
      rcnt_q  <= '0;
      ph_q    <= PH_DELAY;
      rep_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], i_in};
      level_q <= level_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      neg_q   <= neg_d;
      rcnt_q  <= rcnt_d;
      ph_q    <= ph_d;
      rep_q   <= rep_d;
    end
  end

  assign o_level  = level_q;
  assign o_pos    = pos_q;
  assign o_neg    = neg_q;
  assign o_repeat = rep_q;
endmodule

module debounce_bank #(
  parameter int N_CH          = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 500000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_RATE   = 5000000,
  parameter bit ACTIVE_LOW    = 1'b1,
  parameter bit INIT_LEVEL    = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [N_CH-1:0] i_in,
  input  logic [N_CH-1:0] i_repeat_en,
  output logic [N_CH-1:0] o_level,
  output logic [N_CH-1:0] o_pos,
  output logic [N_CH-1:0] o_neg,
  output logic [N_CH-1:0] o_repeat,
  output logic            o_any
);
  for (genvar k = 0; k < N_CH; k++) begin : g_lane
    debounce_lane #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_CYCLES(STABLE_CYCLES),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE),
      .ACTIVE_LOW   (ACTIVE_LOW),
      .INIT_LEVEL   (INIT_LEVEL)
    ) u_lane (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_in       (i_in[k]),
      .i_repeat_en(i_repeat_en[k]),
      .o_level    (o_level[k]),
      .o_pos      (o_pos[k]),
      .o_neg      (o_neg[k]),
      .o_repeat   (o_repeat[k])
    );
  end

  // Strobes are already registered, so this OR has no path from i_in.
  assign o_any = |(o_pos | o_neg);
endmodule

// File: tb/tb_debounce_bank.sv
// Bench for debounce_bank: cycle-by-cycle vector table with hand-derived
// expectations, fed through a scoreboard queue, plus a re-enable sequence.
`timescale 1ns/1ps
module tb_debounce_bank;
  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic [3:0] i_in = '0, i_repeat_en = '0;
  logic [3:0] o_level, o_pos, o_neg, o_repeat;
  logic       o_any;

  int checks = 0;
  int errors = 0;

  debounce_bank #(
    .N_CH(4), .SYNC_STAGES(2), .STABLE_CYCLES(4), .REPEAT_DELAY(10),
    .REPEAT_RATE(3), .ACTIVE_LOW(1'b0), .INIT_LEVEL(1'b0)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_in(i_in), .i_repeat_en(i_repeat_en),
    .o_level(o_level), .o_pos(o_pos), .o_neg(o_neg), .o_repeat(o_repeat),
    .o_any(o_any)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic       rst;
    logic [3:0] in, en, lvl, pos, neg, rep;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic ev(input logic r, input logic [3:0] in, en, lvl, pos, neg, rep);
    vec_t v;
    v.rst = r; v.in = in; v.en = en; v.lvl = lvl; v.pos = pos; v.neg = neg; v.rep = rep;
    vecs.push_back(v);
  endtask

  task automatic quiet(input int n, input logic [3:0] in, en, lvl);
    for (int i = 0; i < n; i++) ev(1'b0, in, en, lvl, 4'b0, 4'b0, 4'b0);
  endtask

  task automatic step();
    @(posedge i_clk); #1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t e;
    int   n;

    // Reset with random inputs, then release with inputs low.
    for (int i = 0; i < 3; i++) ev(1'b1, 4'($urandom), 4'($urandom), 4'b0, 4'b0, 4'b0, 4'b0);
    quiet(4, 4'b0000, 4'b0000, 4'b0000);
    // Clean step on ch0: level and o_pos on the 6th edge.
    quiet(5, 4'b0001, 4'b0000, 4'b0000);
    ev(1'b0, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
    quiet(2, 4'b0001, 4'b0000, 4'b0001);
    // Glitches on ch1: 3 high / 1 low / 3 high / 1 low rejected, then a held high.
    quiet(3, 4'b0011, 4'b0000, 4'b0001);
    quiet(1, 4'b0001, 4'b0000, 4'b0001);
    quiet(3, 4'b0011, 4'b0000, 4'b0001);
    quiet(1, 4'b0001, 4'b0000, 4'b0001);
    quiet(5, 4'b0011, 4'b0000, 4'b0001);
    ev(1'b0, 4'b0011, 4'b0000, 4'b0011, 4'b0010, 4'b0000, 4'b0000);
    quiet(2, 4'b0011, 4'b0000, 4'b0011);
    // Auto-repeat on ch2: press at P, repeats at P+10, +13, +16, +19.
    quiet(5, 4'b0111, 4'b0100, 4'b0011);
    ev(1'b0, 4'b0111, 4'b0100, 4'b0111, 4'b0100, 4'b0000, 4'b0000);
    quiet(9, 4'b0111, 4'b0100, 4'b0111);
    ev(1'b0, 4'b0111, 4'b0100, 4'b0111, 4'b0000, 4'b0000, 4'b0100);
    quiet(2, 4'b0111, 4'b0100, 4'b0111);
    ev(1'b0, 4'b0111, 4'b0100, 4'b0111, 4'b0000, 4'b0000, 4'b0100);
    quiet(2, 4'b0111, 4'b0100, 4'b0111);
    ev(1'b0, 4'b0111, 4'b0100, 4'b0111, 4'b0000, 4'b0000, 4'b0100);
    // Release from P+17: repeat at P+19, release at P+22 hides the coincident repeat.
    quiet(2, 4'b0011, 4'b0100, 4'b0111);
    ev(1'b0, 4'b0011, 4'b0100, 4'b0111, 4'b0000, 4'b0000, 4'b0100);
    quiet(2, 4'b0011, 4'b0100, 4'b0111);
    ev(1'b0, 4'b0011, 4'b0100, 4'b0011, 4'b0000, 4'b0100, 4'b0000);
    quiet(15, 4'b0011, 4'b0100, 4'b0011);
    // Same press with repeat disabled: no repeats.
    quiet(5, 4'b0111, 4'b0000, 4'b0011);
    ev(1'b0, 4'b0111, 4'b0000, 4'b0111, 4'b0100, 4'b0000, 4'b0000);
    quiet(14, 4'b0111, 4'b0000, 4'b0111);
    quiet(5, 4'b0011, 4'b0000, 4'b0111);
    ev(1'b0, 4'b0011, 4'b0000, 4'b0011, 4'b0000, 4'b0100, 4'b0000);
    quiet(2, 4'b0011, 4'b0000, 4'b0011);
    // Simultaneous: ch3 up / ch1 down, then ch1 up / ch3 down.
    quiet(5, 4'b1001, 4'b0000, 4'b0011);
    ev(1'b0, 4'b1001, 4'b0000, 4'b1001, 4'b1000, 4'b0010, 4'b0000);
    quiet(2, 4'b1001, 4'b0000, 4'b1001);
    quiet(5, 4'b0011, 4'b0000, 4'b1001);
    ev(1'b0, 4'b0011, 4'b0000, 4'b0011, 4'b0010, 4'b1000, 4'b0000);
    quiet(2, 4'b0011, 4'b0000, 4'b0011);
    // Release everything.
    quiet(5, 4'b0000, 4'b0000, 4'b0011);
    ev(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0011, 4'b0000);
    quiet(2, 4'b0000, 4'b0000, 4'b0000);
    // Reset at count 2 of 4, then a full press.
    quiet(4, 4'b0100, 4'b0100, 4'b0000);
    ev(1'b1, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    quiet(5, 4'b0100, 4'b0100, 4'b0000);
    ev(1'b0, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000);
    quiet(9, 4'b0100, 4'b0100, 4'b0100);
    ev(1'b0, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0100);
    quiet(2, 4'b0100, 4'b0100, 4'b0100);
    ev(1'b0, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0100);
    quiet(1, 4'b0100, 4'b0100, 4'b0100);
    // Reset during the RATE phase: level drops silently, full restart follows.
    ev(1'b1, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    quiet(5, 4'b0100, 4'b0100, 4'b0000);
    ev(1'b0, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000);
    quiet(9, 4'b0100, 4'b0100, 4'b0100);
    ev(1'b0, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0100);
    quiet(2, 4'b0000, 4'b0100, 4'b0100);
    ev(1'b0, 4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0100);
    quiet(2, 4'b0000, 4'b0100, 4'b0100);
    ev(1'b0, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000);
    quiet(3, 4'b0000, 4'b0000, 4'b0000);

    foreach (vecs[i]) begin
      i_rst       = vecs[i].rst;
      i_in        = vecs[i].in;
      i_repeat_en = vecs[i].en;
      sb.push_back(vecs[i]);
      step();
      e = sb.pop_front();
      chk($sformatf("v%0d_level", i), 32'(o_level), 32'(e.lvl));
      chk($sformatf("v%0d_pos", i), 32'(o_pos), 32'(e.pos));
      chk($sformatf("v%0d_neg", i), 32'(o_neg), 32'(e.neg));
      chk($sformatf("v%0d_repeat", i), 32'(o_repeat), 32'(e.rep));
      chk($sformatf("v%0d_any", i), 32'(o_any), 32'(|(e.pos | e.neg)));
    end

    // Re-enabling repeat while held restarts the full DELAY phase.
    i_rst = 1'b0;
    i_in = 4'b1000;
    i_repeat_en = 4'b1000;
    n = 0;
    while (!o_pos[3] && n < 20) begin step(); n++; end
    chk("hs_press_latency", 32'(n), 32'd6);
    repeat (5) step();
    i_repeat_en = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("hs_disabled_rep%0d", i), 32'(o_repeat), 32'd0);
    end
    i_repeat_en = 4'b1000;
    n = 0;
    while (!o_repeat[3] && n < 30) begin step(); n++; end
    chk("hs_reenable_delay", 32'(n), 32'd10);
    i_in = 4'b0000;
    i_repeat_en = 4'b0000;
    repeat (8) step();
    chk("hs_final_level", 32'(o_level), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
